// File: rtl/counter_seq.sv
// counter_seq: command-driven up/down counter with start, stop and pause.
// A START loads an initial count, latches the terminal count and direction,
// and runs until the count matches the terminal value, then pulses done.
// Optional build macro COUNTER_SEQ_AUTORELOAD_EN: on terminal match the
// counter reloads its start value and keeps running until a STOP arrives.
module counter_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_down,
  output logic [WIDTH-1:0] counter_output,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_START  = 2'b01;
  localparam logic [1:0] OP_STOP   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] start_q;
  logic             down_q;

  logic             accept;
  logic             at_limit;
  logic [WIDTH-1:0] next_count;

  // NOTE: these are plain continuous assigns of state decodes, so no latch
  // can form and cmd_ready/busy depend on the state register alone.
  assign cmd_ready  = (state != S_DONE);
  assign busy       = (state == S_RUN) || (state == S_PAUSE);
  assign accept     = cmd_valid && cmd_ready;
  assign at_limit   = (counter_output == limit_q);
  assign next_count = down_q ? (counter_output - WIDTH'(1))
                             : (counter_output + WIDTH'(1));

  // Control FSM with registered count, done and cmd_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register, including the latched command fields, is
      // cleared so a reset mid-run leaves no stale limit or direction behind.
      state          <= S_IDLE;
      counter_output <= '0;
      limit_q        <= '0;
      start_q        <= '0;
      down_q         <= 1'b0;
      done           <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make done/cmd_err single-cycle pulses;
      // any later assignment in this block for the same edge overrides them.
      done    <= 1'b0;
      cmd_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_START: begin
                counter_output <= cmd_start;
                start_q        <= cmd_start;
                limit_q        <= cmd_limit;
                down_q         <= cmd_down;
                state          <= S_RUN;
              end
              OP_TOGGLE: cmd_err <= 1'b1;
              default:   ;  // STOP and NOP are silent while idle
            endcase
          end
        end

        S_RUN: begin
          if (accept && (cmd_op == OP_STOP)) begin
            // STOP beats a terminal match: abort with no done pulse.
            state <= S_IDLE;
          end else begin
            if (accept && (cmd_op == OP_START)) begin
              cmd_err <= 1'b1;
            end
            if (at_limit) begin
              // Terminal match wins over a pause request on the same edge.
              done <= 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
              counter_output <= start_q;
`else
              state <= S_DONE;
`endif
            end else if (accept && (cmd_op == OP_TOGGLE)) begin
              state <= S_PAUSE;
            end else begin
              counter_output <= next_count;
            end
          end
        end

        S_PAUSE: begin
          if (accept) begin
            case (cmd_op)
              OP_STOP:   state   <= S_IDLE;
              OP_TOGGLE: state   <= S_RUN;
              OP_START:  cmd_err <= 1'b1;
              default:   ;
            endcase
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  // OP_NOP is named for readability of the command map only.
  logic unused_nop;
  assign unused_nop = (OP_NOP == 2'b00);

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed bench for counter_seq. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
// Build with COUNTER_SEQ_AUTORELOAD_EN to exercise the periodic mode.
module tb_counter_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_limit;
  logic         cmd_down;
  logic [W-1:0] counter_output;
  logic         busy;
  logic         done;
  logic         cmd_err;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, TOG = 2'b11;

  counter_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_start      (cmd_start),
    .cmd_limit      (cmd_limit),
    .cmd_down       (cmd_down),
    .counter_output (counter_output),
    .busy           (busy),
    .done           (done),
    .cmd_err        (cmd_err)
  );

  always #5 clk = ~clk;

  // Observation and expectation packed as {count, busy, done, cmd_err, cmd_ready}.
  function automatic logic [W+3:0] obs();
    return {counter_output, busy, done, cmd_err, cmd_ready};
  endfunction

  function automatic logic [W+3:0] ex(input logic [W-1:0] c, input logic b,
                                      input logic d, input logic e, input logic r);
    return {c, b, d, e, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] s,
                      input logic [W-1:0] l, input logic dn);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_start = s;
    cmd_limit = l;
    cmd_down  = dn;
    step();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic test_reset();
    logic [W+3:0] w;
    rst_n = 1'b0;
    step();
    step();
    w = ex(8'd0, 0, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL reset got=%h want=%h", obs(), w); end
    rst_n = 1'b1;
    step();
    total++;
    if (obs() !== w) begin bad++; $display("FAIL reset_release got=%h want=%h", obs(), w); end
  endtask

  task automatic test_up_run();
    logic [W+3:0] w;
    send(START, 8'd0, 8'd5, 1'b0);
    w = ex(8'd0, 1, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL up_load got=%h want=%h", obs(), w); end
    for (int k = 1; k <= 5; k++) begin
      step();
      w = ex(W'(k), 1, 0, 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL up_count%0d got=%h want=%h", k, obs(), w); end
    end
    step();
    w = ex(8'd5, 0, 1, 0, 0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL up_done got=%h want=%h", obs(), w); end
    for (int k = 0; k < 2; k++) begin
      step();
      w = ex(8'd5, 0, 0, 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL up_idle%0d got=%h want=%h", k, obs(), w); end
    end
  endtask

  task automatic test_wrap();
    logic [W+3:0] w;
    logic [W-1:0] dn_seq [4] = '{8'd1, 8'd0, 8'd255, 8'd254};
    logic [W-1:0] up_seq [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
    send(START, 8'd1, 8'd254, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      w = ex(dn_seq[k], 1, 0, 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL down_wrap%0d got=%h want=%h", k, obs(), w); end
    end
    step();
    w = ex(8'd254, 0, 1, 0, 0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL down_done got=%h want=%h", obs(), w); end
    step();
    send(START, 8'd254, 8'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      w = ex(up_seq[k], 1, 0, 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL up_wrap%0d got=%h want=%h", k, obs(), w); end
    end
    step();
    w = ex(8'd1, 0, 1, 0, 0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL up_wrap_done got=%h want=%h", obs(), w); end
    step();
  endtask

  task automatic test_pause_stop();
    logic [W+3:0] w;
    send(START, 8'd10, 8'd20, 1'b0);
    step(); step(); step();
    w = ex(8'd13, 1, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL ps_at13 got=%h want=%h", obs(), w); end
    send(TOG, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      total++;
      if (obs() !== w) begin bad++; $display("FAIL ps_hold%0d got=%h want=%h", k, obs(), w); end
    end
    send(TOG, 8'd0, 8'd0, 1'b0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL ps_resume got=%h want=%h", obs(), w); end
    for (int k = 14; k <= 16; k++) begin
      step();
      w = ex(W'(k), 1, 0, 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL ps_count%0d got=%h want=%h", k, obs(), w); end
    end
    send(STOP, 8'd0, 8'd0, 1'b0);
    w = ex(8'd16, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      total++;
      if (obs() !== w) begin bad++; $display("FAIL ps_stopped%0d got=%h want=%h", k, obs(), w); end
    end
  endtask

  task automatic test_errors();
    logic [W+3:0] w;
    send(START, 8'd0, 8'd3, 1'b0);
    send(START, 8'd9, 8'd9, 1'b0);
    w = ex(8'd1, 1, 0, 1, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL err_start_run got=%h want=%h", obs(), w); end
    step();
    w = ex(8'd2, 1, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL err_pulse_end got=%h want=%h", obs(), w); end
    step();
    send(STOP, 8'd0, 8'd0, 1'b0);
    w = ex(8'd3, 0, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL stop_at_match got=%h want=%h", obs(), w); end
    step();
    total++;
    if (obs() !== w) begin bad++; $display("FAIL stop_no_done got=%h want=%h", obs(), w); end
    send(TOG, 8'd0, 8'd0, 1'b0);
    w = ex(8'd3, 0, 0, 1, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL err_tog_idle got=%h want=%h", obs(), w); end
    send(STOP, 8'd0, 8'd0, 1'b0);
    w = ex(8'd3, 0, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL stop_idle_silent got=%h want=%h", obs(), w); end
    send(START, 8'd7, 8'd8, 1'b0);
    step();
    send(TOG, 8'd0, 8'd0, 1'b0);
    w = ex(8'd8, 0, 1, 0, 0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL tog_at_match got=%h want=%h", obs(), w); end
    step();
    send(START, 8'd5, 8'd5, 1'b0);
    step();
    w = ex(8'd5, 0, 1, 0, 0);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL s_eq_l got=%h want=%h", obs(), w); end
    step();
    send(START, 8'd0, 8'd9, 1'b0);
    send(TOG, 8'd0, 8'd0, 1'b0);
    send(START, 8'd3, 8'd3, 1'b0);
    w = ex(8'd0, 1, 0, 1, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL err_start_pause got=%h want=%h", obs(), w); end
    send(STOP, 8'd0, 8'd0, 1'b0);
    w = ex(8'd0, 0, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL stop_pause got=%h want=%h", obs(), w); end
  endtask

  task automatic test_reset_mid();
    logic [W+3:0] w;
    send(START, 8'd0, 8'd20, 1'b0);
    for (int k = 0; k < 7; k++) step();
    w = ex(8'd7, 1, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL rm_at7 got=%h want=%h", obs(), w); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    w = ex(8'd0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      total++;
      if (obs() !== w) begin bad++; $display("FAIL rm_after%0d got=%h want=%h", k, obs(), w); end
    end
  endtask

`ifdef COUNTER_SEQ_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [W+3:0] w;
    logic [W-1:0] seq [8] = '{8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4};
    logic         dn  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    send(START, 8'd2, 8'd4, 1'b0);
    w = ex(8'd2, 1, 0, 0, 1);
    total++;
    if (obs() !== w) begin bad++; $display("FAIL ar_load got=%h want=%h", obs(), w); end
    for (int k = 0; k < 8; k++) begin
      step();
      w = ex(seq[k], 1, dn[k], 0, 1);
      total++;
      if (obs() !== w) begin bad++; $display("FAIL ar_seq%0d got=%h want=%h", k, obs(), w); end
    end
    send(STOP, 8'd0, 8'd0, 1'b0);
    w = ex(8'd4, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) step();
      total++;
      if (obs() !== w) begin bad++; $display("FAIL ar_stop%0d got=%h want=%h", k, obs(), w); end
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_start = '0;
    cmd_limit = '0;
    cmd_down  = 1'b0;
    #1;
    test_reset();
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    test_autoreload();
`else
    test_up_run();
    test_wrap();
    test_errors();
`endif
    test_pause_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 Parameter: WIDTH, default 8, counter and value width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command accepted on this edge when cmd_valid=1.
REQ-006 cmd_op  input  2  01=START, 10=STOP, 11=PAUSE/RESUME toggle, 00=NOP.
REQ-007 cmd_start  input  WIDTH  initial count; sampled on START only.
REQ-008 cmd_limit  input  WIDTH  terminal count; sampled on START only.
REQ-009 cmd_down  input  1  1=count down, 0=count up; sampled on START only.
REQ-010 counter_output  output  WIDTH  registered count value.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  one-cycle completion pulse, registered.
REQ-013 cmd_err  output  1  one-cycle pulse: an accepted command was illegal in the current state.

Function
REQ-014 States: IDLE, RUN, PAUSE, DONE; the block SHALL hold exactly one state at a time.
REQ-015 cmd_ready SHALL be 1 in IDLE, RUN and PAUSE, and 0 in DONE; it SHALL be a function of state only.
REQ-016 START accepted in IDLE SHALL, on the same edge, load counter_output=cmd_start, latch limit/start/direction, and enter RUN.
REQ-017 In RUN, when counter_output==limit, the block SHALL enter DONE and hold counter_output; otherwise it SHALL step counter_output by +1 (up) or -1 (down), modulo 2^WIDTH.
REQ-018 Wrap-around: up from 2^WIDTH-1 SHALL yield 0; down from 0 SHALL yield 2^WIDTH-1.
REQ-019 Latency: START accepted at edge N with start=S and limit=L (up, L>=S) SHALL give counter_output==L after edge N+(L-S), and done=1 for the cycle following edge N+(L-S)+1.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; counter_output SHALL hold its value in IDLE.
REQ-021 S==L SHALL enter DONE on the first RUN edge (N+1).
REQ-022 STOP accepted in RUN or PAUSE SHALL enter IDLE on that edge, hold counter_output, and not assert done.
REQ-023 PAUSE/RESUME SHALL move RUN to PAUSE and PAUSE to RUN; counter_output SHALL hold while in PAUSE.
REQ-024 START in RUN or PAUSE, and PAUSE/RESUME in IDLE, SHALL be accepted, otherwise ignored, and SHALL pulse cmd_err for one cycle.
REQ-025 STOP and NOP in IDLE SHALL be silent no-ops with no cmd_err.
REQ-026 Simultaneous events: STOP in the terminal-match cycle SHALL win (IDLE, no done); PAUSE/RESUME in the terminal-match cycle SHALL be consumed without error, and the terminal transition SHALL win.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, counter_output=0, done=0, busy=0, cmd_err=0, latched limit/start/direction=0.
REQ-028 Reset mid-operation (RUN, PAUSE or DONE) SHALL abort without a done pulse; cmd_ready SHALL read 1 from the first cycle after reset.

Configuration
REQ-029 Macro COUNTER_SEQ_AUTORELOAD_EN.
- Defined: on terminal match in RUN, the block SHALL reload counter_output with the latched start value, stay in RUN, and pulse done for the following cycle. DONE is never entered. The counter runs periodically until STOP.
- Undefined: one-shot behaviour per REQ-017 to REQ-020.

Verification
REQ-030 Up run: START S=0, L=5, up -> counter 0,1,2,3,4,5; done=1 exactly once, one cycle after the count reaches 5; then IDLE holding 5, busy=0.
REQ-031 Down wrap: START S=1, L=254, down -> counter 1,0,255,254; then done; busy high throughout RUN.
REQ-032 Pause/stop: START S=10, L=20; PAUSE at count 13 -> count holds at 13 for 4 cycles; RESUME -> count continues from 14; STOP at 16 -> IDLE, counter=16, no done.
REQ-033 Errors and priority: START during RUN -> cmd_err 1 cycle, count unaffected; STOP in the terminal-match cycle -> IDLE, done stays 0; PAUSE in IDLE -> cmd_err pulse.
REQ-034 Reset mid-run: rst_n=0 for 1 cycle at count 7 -> counter=0, busy=0, done=0, cmd_ready=1.
REQ-035 With COUNTER_SEQ_AUTORELOAD_EN: START S=2, L=4, up -> sequence 2,3,4,2,3,4,...; done pulses every 3 cycles; STOP ends the run with no done.
